// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller for the 4-bit CPU. It runs the 8-phase machine
// cycle (A1,A2,A3,M1,M2,X1,X2,X3 = 0..7) and owns the program counter. It also
// captures the two ROM nibbles of each frame and assembles one- and two-word
// instructions for the decode/execute stage.
//
// Parameters
//    ADDR_W      PC / ROM address width
//    RESET_PC    PC value after reset
//
// Ports
//    clk          in   system clock, all state on the rising edge
//    rst_n        in   asynchronous active-low reset
//    run          in   1 = advance, 0 = freeze all state
//    rom_nibble   in   ROM data, only meaningful in phases M1 (3) and M2 (4)
//    jump_req     in   load jump_addr as the next PC (sampled in phase X3)
//    jump_addr    in   jump target
//    cycle        out  current machine phase 0..7
//    sync         out  high during phase X3 (frame end)
//    rom_addr     out  fetch address (= PC), stable for a whole frame
//    opr          out  upper nibble of the first instruction word
//    opa          out  lower nibble of the first instruction word
//    word2        out  second instruction word (valid when two_byte=1)
//    two_byte     out  current instruction is a two-word instruction
//    instr_valid  out  one-clock pulse in phase X1 when an instruction is complete
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [3:0]        rom_nibble,
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [2:0]        cycle,
   output logic              sync,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [3:0]        opr,
   output logic [3:0]        opa,
   output logic [7:0]        word2,
   output logic              two_byte,
   output logic              instr_valid
);

   typedef enum logic [2:0] {
      PH_A1 = 3'd0,
      PH_A2 = 3'd1,
      PH_A3 = 3'd2,
      PH_M1 = 3'd3,
      PH_M2 = 3'd4,
      PH_X1 = 3'd5,
      PH_X2 = 3'd6,
      PH_X3 = 3'd7
   } phase_t;

   phase_t            phase_q,    phase_d;
   logic [ADDR_W-1:0] pc_q,       pc_d;
   logic [3:0]        hi_q,       hi_d;
   logic [3:0]        opr_q,      opr_d;
   logic [3:0]        opa_q,      opa_d;
   logic [7:0]        word2_q,    word2_d;
   logic              two_byte_q, two_byte_d;
   logic              pending_q,  pending_d;
   logic              valid_q,    valid_d;

   // Opcodes whose first word is followed by a second fetched word:
   // JCN (1), FIM (2 with even modifier), JUN (4), JMS (5), ISZ (7).
   function automatic logic is_two_word(input logic [3:0] op, input logic [3:0] mod);
      logic res;
      res = 1'b0;
      case (op)
         4'h1, 4'h4, 4'h5, 4'h7: res = 1'b1;
         4'h2:                   res = ~mod[0];
         default:                res = 1'b0;
      endcase
      return res;
   endfunction

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= PH_A1;
         pc_q       <= RESET_PC;
         hi_q       <= 4'h0;
         opr_q      <= 4'h0;
         opa_q      <= 4'h0;
         word2_q    <= 8'h00;
         two_byte_q <= 1'b0;
         pending_q  <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         pc_q       <= pc_d;
         hi_q       <= hi_d;
         opr_q      <= opr_d;
         opa_q      <= opa_d;
         word2_q    <= word2_d;
         two_byte_q <= two_byte_d;
         pending_q  <= pending_d;
         valid_q    <= valid_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      phase_d    = phase_q;
      pc_d       = pc_q;
      hi_d       = hi_q;
      opr_d      = opr_q;
      opa_d      = opa_q;
      word2_d    = word2_q;
      two_byte_d = two_byte_q;
      pending_d  = pending_q;
      // The pulse lives for exactly one edge: any edge out of X1, whether it
      // advances or not, clears it so a frozen X1 never re-issues it.
      valid_d    = 1'b0;

      if (run) begin
         phase_d = phase_t'(phase_q + 3'd1);

         case (phase_q)
            PH_M1: begin
               hi_d = rom_nibble;
            end

            PH_M2: begin
               // Commit uses the fresh low nibble straight off the bus.
               if (pending_q) begin
                  word2_d   = {hi_q, rom_nibble};
                  pending_d = 1'b0;
                  valid_d   = 1'b1;
               end else begin
                  opr_d = hi_q;
                  opa_d = rom_nibble;
                  if (is_two_word(hi_q, rom_nibble)) begin
                     pending_d  = 1'b1;
                     two_byte_d = 1'b1;
                  end else begin
                     two_byte_d = 1'b0;
                     valid_d    = 1'b1;
                  end
               end
            end

            PH_X3: begin
               if (jump_req) begin
                  pc_d      = jump_addr;
                  // A jump abandons any half-fetched two-word instruction.
                  pending_d = 1'b0;
               end else begin
                  pc_d = pc_q + ADDR_W'(1);
               end
            end

            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign cycle       = phase_q;
   assign sync        = (phase_q == PH_X3);
   assign rom_addr    = pc_q;
   assign opr         = opr_q;
   assign opa         = opa_q;
   assign word2       = word2_q;
   assign two_byte    = two_byte_q;
   // Dropping run during X1 withdraws the pulse immediately.
   assign instr_valid = valid_q & run;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b1;
   logic [3:0]  rom_nibble;
   logic        jump_req = 1'b0;
   logic [11:0] jump_addr = 12'h000;
   logic [2:0]  cycle;
   logic        sync;
   logic [11:0] rom_addr;
   logic [3:0]  opr;
   logic [3:0]  opa;
   logic [7:0]  word2;
   logic        two_byte;
   logic        instr_valid;

   fetch_sequencer #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .rom_nibble  (rom_nibble),
      .jump_req    (jump_req),
      .jump_addr   (jump_addr),
      .cycle       (cycle),
      .sync        (sync),
      .rom_addr    (rom_addr),
      .opr         (opr),
      .opa         (opa),
      .word2       (word2),
      .two_byte    (two_byte),
      .instr_valid (instr_valid)
   );

   always #5 clk = ~clk;

   // Program ROM: byte per address; high nibble on M1, low nibble on M2,
   // junk on the bus in every other phase.
   logic [7:0] rom [0:4095];
   assign rom_nibble = (cycle == 3'd3) ? rom[rom_addr][7:4] :
                       (cycle == 3'd4) ? rom[rom_addr][3:0] : 4'hE;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: frame-level view. Each frame fetches the whole byte at
   // the PC; a byte either completes an instruction or opens a two-word one.
   // ---------------------------------------------------------------------
   int         m_phase = 0;
   int         m_pc = 0;
   bit         m_pend = 0;
   bit         m_armed = 0;
   logic [3:0] m_opr = 0;
   logic [3:0] m_opa = 0;
   logic [7:0] m_w2 = 0;
   bit         m_two = 0;

   function automatic bit two_word(input logic [7:0] b);
      int op;
      op = int'(b[7:4]);
      return (op == 1) || (op == 4) || (op == 5) || (op == 7) || (op == 2 && b[0] == 1'b0);
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_phase = 0; m_pc = 0; m_pend = 0; m_armed = 0;
         m_opr = 0; m_opa = 0; m_w2 = 0; m_two = 0;
      end else begin
         m_armed = 0;
         if (run) begin
            if (m_phase == 4) begin
               logic [7:0] b;
               b = rom[m_pc];
               if (m_pend) begin
                  m_w2 = b; m_pend = 0; m_armed = 1;
               end else begin
                  m_opr = b[7:4]; m_opa = b[3:0];
                  if (two_word(b)) begin
                     m_pend = 1; m_two = 1;
                  end else begin
                     m_two = 0; m_armed = 1;
                  end
               end
            end
            if (m_phase == 7) begin
               if (jump_req) begin
                  m_pc = int'(jump_addr); m_pend = 0;
               end else begin
                  m_pc = (m_pc + 1) % 4096;
               end
            end
            m_phase = (m_phase + 1) % 8;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Per-cycle compare and pulse recorder
   // ---------------------------------------------------------------------
   typedef struct {
      logic [3:0]  opr;
      logic [3:0]  opa;
      logic [7:0]  w2;
      logic        two;
      logic [11:0] addr;
   } pulse_t;
   pulse_t pq[$];

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("cycle", 32'(cycle), 32'(m_phase));
         chk("sync", 32'(sync), 32'(m_phase == 7));
         chk("rom_addr", 32'(rom_addr), 32'(m_pc));
         chk("instr_valid", 32'(instr_valid), 32'(m_armed && run && rst_n && m_phase == 5));
         chk("opr", 32'(opr), 32'(m_opr));
         chk("opa", 32'(opa), 32'(m_opa));
         chk("word2", 32'(word2), 32'(m_w2));
         chk("two_byte", 32'(two_byte), 32'(m_two));
         if (instr_valid) pq.push_back('{opr, opa, word2, two_byte, rom_addr});
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers (inputs change 2 time units after a rising edge)
   // ---------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_phase(input int p);
      int k;
      k = 0;
      while (m_phase != p && k < 16) begin
         step(1);
         k++;
      end
      chk("wait_phase", 32'(m_phase), 32'(p));
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b1; jump_req = 1'b0; jump_addr = 12'h000;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      pq.delete();
   endtask

   task automatic chk_pulse(input string name, input int idx, input logic [3:0] e_opr,
                            input logic [3:0] e_opa, input logic [7:0] e_w2,
                            input logic e_two, input logic [11:0] e_addr);
      if (idx >= pq.size()) begin
         chk({name, "_present"}, 32'(pq.size()), 32'(idx + 1));
      end else begin
         chk({name, "_opr"}, 32'(pq[idx].opr), 32'(e_opr));
         chk({name, "_opa"}, 32'(pq[idx].opa), 32'(e_opa));
         chk({name, "_word2"}, 32'(pq[idx].w2), 32'(e_w2));
         chk({name, "_two"}, 32'(pq[idx].two), 32'(e_two));
         chk({name, "_addr"}, 32'(pq[idx].addr), 32'(e_addr));
      end
   endtask

   initial begin
      rom_clear();
      @(posedge clk);
      #2;
      chk_en = 1'b1;

      // Reset state
      chk("rst_cycle", 32'(cycle), 32'd0);
      chk("rst_sync", 32'(sync), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'h000);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_opr", 32'({opr, opa}), 32'h00);
      chk("rst_word2", 32'(word2), 32'h00);
      chk("rst_two", 32'(two_byte), 32'd0);

      // 1: three one-word instructions
      rom_clear();
      rom[0] = 8'h00; rom[1] = 8'h85; rom[2] = 8'h97; rom[3] = 8'h00;
      do_reset();
      step(24);
      chk("t1_count", 32'(pq.size()), 32'd3);
      chk_pulse("t1_p0", 0, 4'h0, 4'h0, 8'h00, 1'b0, 12'h000);
      chk_pulse("t1_p1", 1, 4'h8, 4'h5, 8'h00, 1'b0, 12'h001);
      chk_pulse("t1_p2", 2, 4'h9, 4'h7, 8'h00, 1'b0, 12'h002);
      $display("txn t1: one-word fetches, %0d pulses", pq.size());

      // 2: JUN 0x012
      rom_clear();
      rom[0] = 8'h40; rom[1] = 8'h12;
      do_reset();
      step(16);
      chk("t2_count", 32'(pq.size()), 32'd1);
      chk_pulse("t2_p0", 0, 4'h4, 4'h0, 8'h12, 1'b1, 12'h001);
      $display("txn t2: two-word JUN, %0d pulses", pq.size());

      // 3: SRC then FIM
      rom_clear();
      rom[0] = 8'h21; rom[1] = 8'h20; rom[2] = 8'hAB;
      do_reset();
      step(24);
      chk("t3_count", 32'(pq.size()), 32'd2);
      chk_pulse("t3_p0", 0, 4'h2, 4'h1, 8'h00, 1'b0, 12'h000);
      chk_pulse("t3_p1", 1, 4'h2, 4'h0, 8'hAB, 1'b1, 12'h002);
      $display("txn t3: SRC + FIM, %0d pulses", pq.size());

      // 4a: jump in X3
      rom_clear();
      do_reset();
      wait_phase(7);
      jump_req = 1'b1; jump_addr = 12'h3A0;
      step(1);
      jump_req = 1'b0;
      chk("t4_jump_addr", 32'(rom_addr), 32'h3A0);
      $display("txn t4a: jump to 3A0, rom_addr=%03h", rom_addr);

      // 4b: jump request only in X2 is ignored
      do_reset();
      wait_phase(6);
      jump_req = 1'b1; jump_addr = 12'h3A0;
      step(1);
      jump_req = 1'b0;
      step(1);
      chk("t4_nojump_addr", 32'(rom_addr), 32'h001);
      $display("txn t4b: jump in cycle 6 ignored, rom_addr=%03h", rom_addr);

      // 5a: PC wrap
      wait_phase(7);
      jump_req = 1'b1; jump_addr = 12'hFFF;
      step(1);
      jump_req = 1'b0;
      chk("t5_fff", 32'(rom_addr), 32'hFFF);
      wait_phase(7);
      step(1);
      chk("t5_wrap", 32'(rom_addr), 32'h000);
      $display("txn t5a: PC wrap FFF -> %03h", rom_addr);

      // 5b: jump while a two-word instruction is pending
      rom_clear();
      rom[0] = 8'h40; rom[12'h100] = 8'h85;
      do_reset();
      wait_phase(7);
      jump_req = 1'b1; jump_addr = 12'h100;
      step(1);
      jump_req = 1'b0;
      step(8);
      chk("t5b_count", 32'(pq.size()), 32'd1);
      chk_pulse("t5b_p0", 0, 4'h8, 4'h5, 8'h00, 1'b0, 12'h100);
      $display("txn t5b: jump discards pending, %0d pulses", pq.size());

      // 6a: freeze at A3 for 5 clocks
      rom_clear();
      rom[1] = 8'h85;
      do_reset();
      wait_phase(2);
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("t6_frozen_cycle", 32'(cycle), 32'd2);
         chk("t6_frozen_addr", 32'(rom_addr), 32'h000);
      end
      run = 1'b1;
      step(14);
      chk("t6_count", 32'(pq.size()), 32'd2);
      chk_pulse("t6_p0", 0, 4'h0, 4'h0, 8'h00, 1'b0, 12'h000);
      chk_pulse("t6_p1", 1, 4'h8, 4'h5, 8'h00, 1'b0, 12'h001);
      $display("txn t6a: freeze at cycle 2, %0d pulses", pq.size());

      // 6a': run dropped during X1 withdraws the pulse for good
      rom_clear();
      rom[0] = 8'h85;
      do_reset();
      wait_phase(5);
      chk("t6_pulse_before", 32'(instr_valid), 32'd1);
      run = 1'b0;
      #1;
      chk("t6_pulse_killed", 32'(instr_valid), 32'd0);
      step(3);
      run = 1'b1;
      step(10);
      chk("t6_reissue_count", 32'(pq.size()), 32'd1);
      chk_pulse("t6_next", 0, 4'h0, 4'h0, 8'h00, 1'b0, 12'h001);
      $display("txn t6b: run low in cycle 5, %0d pulses", pq.size());

      // 6b: asynchronous reset in M2
      rom_clear();
      rom[0] = 8'h85;
      do_reset();
      step(8);
      wait_phase(4);
      rst_n = 1'b0;
      #1;
      chk("t6_async_cycle", 32'(cycle), 32'd0);
      chk("t6_async_addr", 32'(rom_addr), 32'h000);
      chk("t6_async_valid", 32'(instr_valid), 32'd0);
      step(2);
      rst_n = 1'b1;
      step(8);
      $display("txn t6c: async reset at cycle 4, rom_addr=%03h", rom_addr);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
